// File: rtl/enc_word_packer.sv
// enc_word_packer: packs encrypted bytes little-endian into words,
// with an XOR checksum, a byte count and a single output holding slot.
module enc_word_packer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int DATA_W         = 8,
    parameter int LEN_W          = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [DATA_W-1:0]                in_byte,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             flush,
    output logic                             flush_ack,
    output logic [DATA_W*BYTES_PER_WORD-1:0] out_word,
    output logic [DATA_W-1:0]                out_chk,
    output logic [LEN_W-1:0]                 out_len,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int WORD_W = DATA_W * BYTES_PER_WORD;
    localparam int CNT_W  = (BYTES_PER_WORD > 2) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] chk_q, chk_d;
    logic              ovld_q, ovld_d;
    logic [WORD_W-1:0] oword_q, oword_d;
    logic [DATA_W-1:0] ochk_q, ochk_d;
    logic [LEN_W-1:0]  olen_q, olen_d;

    logic              slot_free;
    logic              accept;
    logic              emit;
    logic [WORD_W-1:0] acc_nx;
    logic [DATA_W-1:0] chk_nx;
    logic [LEN_W-1:0]  len_nx;

    // Handshake decisions: the final lane may only fill when the slot can take the word
    always_comb begin
        slot_free = !ovld_q || out_ready;
        in_ready  = slot_free || (cnt_q != LAST);
        accept    = in_valid && in_ready;
        flush_ack = flush && slot_free && ((cnt_q != '0) || accept);
        emit      = (accept && (cnt_q == LAST)) || flush_ack;
    end

    // Accumulator, checksum and length including this cycle's accepted byte
    always_comb begin
        acc_nx = acc_q;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (accept && (cnt_q == CNT_W'(i))) begin
                acc_nx[i*DATA_W +: DATA_W] = in_byte;
            end
        end
        chk_nx = chk_q ^ (accept ? in_byte : '0);
        len_nx = LEN_W'(cnt_q) + LEN_W'(accept);
    end

    // Next state: emit moves the word into the slot and restarts the accumulator
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        chk_d   = chk_q;
        ovld_d  = ovld_q;
        oword_d = oword_q;
        ochk_d  = ochk_q;
        olen_d  = olen_q;
        if (emit) begin
            oword_d = acc_nx;
            ochk_d  = chk_nx;
            olen_d  = len_nx;
            ovld_d  = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            chk_d   = '0;
        end else begin
            acc_d = acc_nx;
            chk_d = chk_nx;
            cnt_d = cnt_q + CNT_W'(accept);
            if (ovld_q && out_ready) begin
                ovld_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            chk_q   <= '0;
            ovld_q  <= 1'b0;
            oword_q <= '0;
            ochk_q  <= '0;
            olen_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            chk_q   <= chk_d;
            ovld_q  <= ovld_d;
            oword_q <= oword_d;
            ochk_q  <= ochk_d;
            olen_q  <= olen_d;
        end
    end

    assign out_word  = oword_q;
    assign out_chk   = ochk_q;
    assign out_len   = olen_q;
    assign out_valid = ovld_q;

endmodule

// File: tb/tb_enc_word_packer.sv
// tb_enc_word_packer: table vectors plus hand sequences; emitted words
// are checked against a queue of expected words.
module tb_enc_word_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        flush_ack;
    logic [31:0] out_word;
    logic [7:0]  out_chk;
    logic [2:0]  out_len;
    logic        out_valid;
    logic        out_ready = 1'b0;

    enc_word_packer #(.BYTES_PER_WORD(4), .DATA_W(8), .LEN_W(3)) dut (
        .clock(clock), .reset(reset),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .flush_ack(flush_ack),
        .out_word(out_word), .out_chk(out_chk), .out_len(out_len),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] w;
        logic [7:0]  c;
        logic [2:0]  l;
    } exp_t;

    // mode 0: full word, 1: flush in a separate cycle, 2: flush with last byte
    typedef struct {
        int          n;
        logic [31:0] b;
        int          mode;
        logic [31:0] w;
        logic [7:0]  c;
        logic [2:0]  l;
    } vec_t;

    exp_t q[$];
    vec_t tbl[6];
    int   total = 0;
    int   bad = 0;
    logic seen_ready;
    logic seen_ack;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] b,
                       input logic f, input logic r);
        in_valid  = v;
        in_byte   = b;
        flush     = f;
        out_ready = r;
        @(negedge clock);
        seen_ready = in_ready;
        seen_ack   = flush_ack;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard: every transferred word must match the oldest expectation
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_word", out_word, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_word", out_word, e.w);
                check("sb_chk", {24'h0, out_chk}, {24'h0, e.c});
                check("sb_len", {29'h0, out_len}, {29'h0, e.l});
            end
        end
    end

    initial begin
        logic f;

        tbl[0] = '{4, 32'h44332211, 0, 32'h44332211, 8'h44, 3'd4};
        tbl[1] = '{2, 32'h00005AA5, 1, 32'h00005AA5, 8'hFF, 3'd2};
        tbl[2] = '{4, 32'hF0302010, 2, 32'hF0302010, 8'hF0, 3'd4};
        tbl[3] = '{1, 32'h0000007E, 1, 32'h0000007E, 8'h7E, 3'd1};
        tbl[4] = '{3, 32'h00040201, 2, 32'h00040201, 8'h07, 3'd3};
        tbl[5] = '{4, 32'h01FF00FF, 0, 32'h01FF00FF, 8'h01, 3'd4};

        do_reset();
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_word", out_word, 32'h0);
        check("rst_chk", {24'h0, out_chk}, 32'h0);
        check("rst_len", {29'h0, out_len}, 32'h0);

        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check("empty_flush_ack", {31'h0, seen_ack}, 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("empty_flush_valid", {31'h0, out_valid}, 32'h0);

        for (int k = 0; k < 6; k++) begin
            q.push_back({tbl[k].w, tbl[k].c, tbl[k].l});
            for (int i = 0; i < tbl[k].n; i++) begin
                f = (tbl[k].mode == 2) && (i == tbl[k].n - 1);
                cyc(1'b1, tbl[k].b[i*8 +: 8], f, 1'b1);
                check($sformatf("v%0d_rdy%0d", k, i),
                      {31'h0, seen_ready}, 32'h1);
                if (f) check($sformatf("v%0d_ack", k),
                             {31'h0, seen_ack}, 32'h1);
            end
            if (tbl[k].mode == 1) begin
                cyc(1'b0, 8'h00, 1'b1, 1'b1);
                check($sformatf("v%0d_ack", k), {31'h0, seen_ack}, 32'h1);
            end
            check($sformatf("v%0d_vld", k), {31'h0, out_valid}, 32'h1);
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
            check($sformatf("v%0d_drop", k), {31'h0, out_valid}, 32'h0);
        end

        // Stalled consumer: second word fills except its final byte
        q.push_back({32'h04030201, 8'h04, 3'd4});
        q.push_back({32'h08070605, 8'h0C, 3'd4});
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        check("stall_vld", {31'h0, out_valid}, 32'h1);
        for (int i = 5; i <= 7; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            check($sformatf("stall_rdy%0d", i), {31'h0, seen_ready}, 32'h1);
            check($sformatf("stall_hold%0d", i), out_word, 32'h04030201);
        end
        cyc(1'b1, 8'h08, 1'b0, 1'b0);
        check("stall_block", {31'h0, seen_ready}, 32'h0);
        check("stall_hold8", out_word, 32'h04030201);
        cyc(1'b1, 8'h08, 1'b0, 1'b1);
        check("stall_go", {31'h0, seen_ready}, 32'h1);
        check("nogap_vld", {31'h0, out_valid}, 32'h1);
        check("nogap_word", out_word, 32'h08070605);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("stall_drop", {31'h0, out_valid}, 32'h0);

        // Reset mid-word discards the partial bytes
        cyc(1'b1, 8'h01, 1'b0, 1'b1);
        cyc(1'b1, 8'h02, 1'b0, 1'b1);
        do_reset();
        check("rstA_vld", {31'h0, out_valid}, 32'h0);
        q.push_back({32'hA4A3A2A1, 8'h04, 3'd4});
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b1);
        check("rstA_new", out_word, 32'hA4A3A2A1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset while a word is held discards it
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b1, 8'h66, 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 8'h88, 1'b0, 1'b0);
        check("rstB_held", out_word, 32'h88776655);
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        do_reset();
        check("rstB_vld", {31'h0, out_valid}, 32'h0);
        check("rstB_word", out_word, 32'h0);
        q.push_back({32'hB4B3B2B1, 8'h04, 3'd4});
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b1);
        check("rstB_new", out_word, 32'hB4B3B2B1);
        check("rstB_len", {29'h0, out_len}, 32'h4);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        check("sb_empty", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
